vga_line_prefetch: RTL and testbench

- Pixel source that sits directly upstream of the 1152x864 VGA timing driver.
- Consumes the driver's h_addr/v_addr and returns the 12-bit RGB444 vga_data.
- Holds a SRC_W x SRC_H framebuffer in external memory, shown at integer scale 2^SCALE_SHIFT.
- Prefetches the next source row into one half of a ping-pong line buffer while the other half is displayed.

---
 rtl/vga_line_prefetch_if.sv | 21 ++
 rtl/vga_line_prefetch.sv | 167 ++++++++++++++++
 tb/tb_vga_line_prefetch.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_line_prefetch_if.sv
// Read-request bus between the line prefetcher and external pixel memory.
// Requests handshake on req/ready; responses come back in order on rvalid.
interface vga_line_prefetch_if #(
  parameter int ADDR_W = 17
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [11:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vga_line_prefetch.sv
// Scaled framebuffer pixel source: displays one source row from a ping-pong
// line buffer while the next row is fetched from external memory.
module vga_line_prefetch #(
  parameter int SRC_W           = 288,
  parameter int SRC_H           = 216,
  parameter int SCALE_SHIFT     = 2,
  parameter int ADDR_W          = 17,
  parameter int BASE_ADDR       = 0,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic [10:0]          h_addr,
  input  logic [10:0]          v_addr,
  output logic [11:0]          vga_data,
  vga_line_prefetch_if.master  mem,
  output logic                 fetch_busy,
  output logic                 underrun
);
  localparam int COL_W = $clog2(SRC_W);
  localparam int CNT_W = $clog2(SRC_W + 1);
  localparam int ROW_W = $clog2(SRC_H);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FLUSH} state_t;

  state_t            state;
  logic [10:0]       v_prev;
  logic [ROW_W-1:0]  row;
  logic [ROW_W-1:0]  tag [2];
  logic [1:0]        bank_valid;
  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  wptr;
  logic [OUT_W-1:0]  outstanding;
  logic              req_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic [11:0] line_ram [2][SRC_W];

  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(r) * ADDR_W'(SRC_W);
  endfunction

  logic [10:0]      src_row, src_col;
  logic             disp_bank, disp_hit;
  logic             v_change, trig_zero, trig_next, trig;
  logic [ROW_W-1:0] trig_row;
  logic             accept, rsp, last_col, wr_en;
  logic [OUT_W-1:0] out_next;

  assign src_row   = v_addr >> SCALE_SHIFT;
  assign src_col   = h_addr >> SCALE_SHIFT;
  assign disp_bank = src_row[0];
  assign disp_hit  = bank_valid[disp_bank] && (11'(tag[disp_bank]) == src_row);

  assign v_change  = (v_addr != v_prev);
  assign trig_zero = v_change && (v_addr == 11'd0);
  assign trig_next = v_change && (&v_addr[SCALE_SHIFT-1:0]) &&
                     ((src_row + 11'd1) < 11'(SRC_H));
  assign trig      = trig_zero || trig_next;
  assign trig_row  = trig_zero ? '0 : ROW_W'(src_row + 11'd1);

  assign accept   = req_reg && mem.mem_ready;
  assign rsp      = mem.mem_rvalid;
  assign out_next = outstanding + OUT_W'(accept) - OUT_W'(rsp);
  assign last_col = (col == CNT_W'(SRC_W - 1));
  // Responses arriving while flushing belong to an abandoned row.
  assign wr_en    = rsp && (state == REQ || state == DRAIN) && (wptr < CNT_W'(SRC_W));

  assign mem.mem_req  = req_reg;
  assign mem.mem_addr = addr_reg;

  always_ff @(posedge pclk) begin
    if (wr_en)
      line_ram[row[0]][wptr[COL_W-1:0]] <= mem.mem_rdata;
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      v_prev      <= '0;
      row         <= '0;
      tag[0]      <= '0;
      tag[1]      <= '0;
      bank_valid  <= '0;
      col         <= '0;
      wptr        <= '0;
      outstanding <= '0;
      req_reg     <= 1'b0;
      addr_reg    <= '0;
      vga_data    <= '0;
      fetch_busy  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      v_prev      <= v_addr;
      outstanding <= out_next;
      vga_data    <= (disp_hit && src_col < 11'(SRC_W)) ?
                     line_ram[disp_bank][src_col[COL_W-1:0]] : 12'h000;
      if (!disp_hit && h_addr != 11'd0)
        underrun <= 1'b1;
      if (wr_en)
        wptr <= wptr + 1'b1;

      case (state)
        IDLE: begin
          if (trig) begin
            row                  <= trig_row;
            tag[trig_row[0]]     <= trig_row;
            bank_valid[trig_row[0]] <= 1'b0;
            col                  <= '0;
            wptr                 <= '0;
            addr_reg             <= row_base(trig_row);
            req_reg              <= 1'b1;
            fetch_busy           <= 1'b1;
            state                <= REQ;
          end
        end
        REQ, DRAIN: begin
          if (trig) begin
            // A request already on the bus is held until accepted, then discarded.
            row                  <= trig_row;
            tag[trig_row[0]]     <= trig_row;
            bank_valid[trig_row[0]] <= 1'b0;
            underrun             <= 1'b1;
            if (accept)
              req_reg <= 1'b0;
            state <= FLUSH;
          end else if (state == REQ) begin
            if (accept) begin
              col      <= col + 1'b1;
              addr_reg <= addr_reg + 1'b1;
              if (last_col) begin
                req_reg <= 1'b0;
                state   <= DRAIN;
              end else begin
                req_reg <= (out_next < OUT_W'(MAX_OUTSTANDING));
              end
            end else if (!req_reg) begin
              req_reg <= (out_next < OUT_W'(MAX_OUTSTANDING));
            end
          end else if (wptr == CNT_W'(SRC_W)) begin
            bank_valid[row[0]] <= 1'b1;
            fetch_busy         <= 1'b0;
            state              <= IDLE;
          end
        end
        FLUSH: begin
          if (accept)
            req_reg <= 1'b0;
          if (trig) begin
            row                  <= trig_row;
            tag[trig_row[0]]     <= trig_row;
            bank_valid[trig_row[0]] <= 1'b0;
            underrun             <= 1'b1;
          end else if (!req_reg && outstanding == '0) begin
            col      <= '0;
            wptr     <= '0;
            addr_reg <= row_base(row);
            req_reg  <= 1'b1;
            state    <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_line_prefetch.sv
// Scoreboard bench for vga_line_prefetch: a memory model checks request
// addresses against expected queues, a pixel monitor checks vga_data.
module tb_vga_line_prefetch;
  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] h_addr = '0;
  logic [10:0] v_addr = '0;
  logic [11:0] vga_data;
  logic        fetch_busy, underrun;

  vga_line_prefetch_if #(.ADDR_W(17)) mem_if ();

  vga_line_prefetch dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .vga_data   (vga_data),
    .mem        (mem_if),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] data_of(input int a);
    int t;
    t = a * 5 + 291;
    return t[11:0];
  endfunction

  // Memory model state
  int          cyc = 0;
  int          lat = 0;
  int          ready_mode = 1;   // 0 stall, 1 always ready, 2 toggle
  int          pend_due[$];
  logic [11:0] pend_data[$];
  logic [16:0] exp_addr[$];
  int          tb_out = 0;
  int          max_out = 0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;

  initial begin
    logic        rdy;
    logic [16:0] ea;
    mem_if.mem_ready  = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    forever begin
      @(negedge pclk);
      cyc++;
      if (reset_n) begin
        if (prev_stall) begin
          checks++;
          if (!(mem_if.mem_req === 1'b1 && mem_if.mem_addr === prev_addr)) begin
            errors++;
            $display("FAIL stall_hold req=%0b addr=%0d required req=1 addr=%0d",
                     mem_if.mem_req, mem_if.mem_addr, prev_addr);
          end
        end
        case (ready_mode)
          0:       rdy = 1'b0;
          1:       rdy = 1'b1;
          default: rdy = cyc[0];
        endcase
        mem_if.mem_ready = rdy;
        if (mem_if.mem_req === 1'b1 && rdy) begin
          checks++;
          if (exp_addr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req addr=%0d required none", mem_if.mem_addr);
          end else begin
            ea = exp_addr.pop_front();
            if (mem_if.mem_addr !== ea) begin
              errors++;
              $display("FAIL req_addr actual=%0d required=%0d", mem_if.mem_addr, ea);
            end
          end
          pend_due.push_back(cyc + lat);
          pend_data.push_back(data_of(int'(mem_if.mem_addr)));
          tb_out++;
        end
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
          void'(pend_due.pop_front());
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = pend_data.pop_front();
          tb_out--;
        end else begin
          mem_if.mem_rvalid = 1'b0;
          mem_if.mem_rdata  = '0;
        end
        if (tb_out > max_out) max_out = tb_out;
        prev_stall = (mem_if.mem_req === 1'b1) && !rdy;
        prev_addr  = mem_if.mem_addr;
      end else begin
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        prev_stall        = 1'b0;
      end
    end
  end

  // Pixel scoreboard: one expected value per driven h_addr, checked a cycle later
  logic [11:0] pix_q[$];
  bit          pix_en = 1'b0;

  initial begin
    bit          cap;
    logic [11:0] e;
    forever begin
      @(posedge pclk);
      cap = pix_en;
      #1;
      if (cap) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL pix_queue_empty actual=%0h", vga_data);
        end else begin
          e = pix_q.pop_front();
          if (vga_data !== e) begin
            errors++;
            $display("FAIL pixel v=%0d actual=%0h required=%0h", v_addr, vga_data, e);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_v(input int v);
    @(negedge pclk);
    v_addr = 11'(v);
  endtask

  task automatic push_fetch(input int r);
    for (int c = 0; c < 288; c++) exp_addr.push_back(17'(r * 288 + c));
  endtask

  task automatic wait_fetch(input string name, input int budget, output int used);
    used = 0;
    @(negedge pclk);
    check({name, "_busy"}, 32'(fetch_busy), 1);
    while (fetch_busy === 1'b1 && used < budget) begin
      @(negedge pclk);
      used++;
    end
    check({name, "_done"}, 32'(fetch_busy), 0);
    check({name, "_reqs_left"}, exp_addr.size(), 0);
    $display("fetch %s finished after %0d cycles", name, used);
  endtask

  task automatic scan_line(input int r, input bit valid, input int n);
    for (int h = 0; h < n; h++) begin
      @(negedge pclk);
      h_addr = 11'(h);
      pix_en = 1'b1;
      pix_q.push_back(valid ? data_of(r * 288 + h / 4) : 12'h000);
    end
    @(negedge pclk);
    pix_en = 1'b0;
    h_addr = '0;
    @(negedge pclk);
    $display("scan v=%0d row=%0d valid=%0b pixels=%0d", v_addr, r, valid, n);
  endtask

  initial begin
    int used;
    int k;
    cycles(3);
    check("reset_vga_data", 32'(vga_data), 0);
    check("reset_mem_req", 32'(mem_if.mem_req), 0);
    check("reset_mem_addr", 32'(mem_if.mem_addr), 0);
    check("reset_fetch_busy", 32'(fetch_busy), 0);
    check("reset_underrun", 32'(underrun), 0);
    @(negedge pclk);
    reset_n = 1'b1;
    cycles(3);

    // Frame start: 863 is the last row (no fetch), then 0 fetches row 0
    ready_mode = 1; lat = 0;
    set_v(863);
    cycles(5);
    check("no_fetch_at_863", 32'(fetch_busy), 0);
    push_fetch(0);
    set_v(0);
    wait_fetch("row0", 400, used);
    check("row0_within_300", 32'(used <= 300), 1);
    scan_line(0, 1'b1, 1152);

    // v 2->3 fetches row 1 into bank1; bank0 keeps row 0
    set_v(1);
    set_v(2);
    push_fetch(1);
    set_v(3);
    wait_fetch("row1", 400, used);
    scan_line(0, 1'b1, 1152);
    set_v(4);
    cycles(2);
    scan_line(1, 1'b1, 1152);
    check("no_underrun_after_row1", 32'(underrun), 0);

    // Toggling ready with 3-cycle response latency
    ready_mode = 2; lat = 3; max_out = 0;
    set_v(5);
    set_v(6);
    push_fetch(2);
    set_v(7);
    wait_fetch("row2", 2000, used);
    check("row2_under_1520", 32'(used < 1520), 1);
    check("row2_max_out_le4", 32'(max_out <= 4), 1);
    set_v(8);
    cycles(2);
    scan_line(2, 1'b1, 1152);

    // Last source row, with long latency so the outstanding limit engages
    ready_mode = 1; lat = 6; max_out = 0;
    set_v(858);
    cycles(3);
    check("no_fetch_at_858", 32'(fetch_busy), 0);
    push_fetch(215);
    set_v(859);
    wait_fetch("row215", 2000, used);
    check("row215_max_out_eq4", max_out, 4);
    set_v(860);
    cycles(2);
    scan_line(215, 1'b1, 1152);
    set_v(863);
    cycles(10);
    check("no_fetch_at_863b", 32'(fetch_busy), 0);
    lat = 0;
    push_fetch(0);
    set_v(0);
    wait_fetch("row0b", 400, used);
    check("underrun_still_clear", 32'(underrun), 0);

    // Memory stalled across the next trigger
    ready_mode = 0; lat = 1;
    exp_addr.push_back(17'd288);
    set_v(3);
    cycles(10);
    check("stall_req_held", 32'(mem_if.mem_req), 1);
    check("stall_addr_288", 32'(mem_if.mem_addr), 288);
    push_fetch(2);
    set_v(7);
    cycles(3);
    check("underrun_set", 32'(underrun), 1);
    set_v(4);
    cycles(2);
    scan_line(1, 1'b0, 1152);
    ready_mode = 1;
    wait_fetch("row2_retry", 2000, used);
    set_v(8);
    cycles(2);
    scan_line(2, 1'b1, 1152);
    set_v(4);
    cycles(2);
    scan_line(1, 1'b0, 64);
    check("underrun_sticky", 32'(underrun), 1);

    // Reset while requests are in flight
    ready_mode = 1; lat = 3;
    push_fetch(3);
    set_v(11);
    k = 0;
    do begin
      @(negedge pclk);
      #2;
      k++;
    end while (tb_out != 2 && k < 50);
    check("reached_two_outstanding", tb_out, 2);
    reset_n = 1'b0;
    v_addr  = '0;
    h_addr  = '0;
    pend_due.delete();
    pend_data.delete();
    exp_addr.delete();
    tb_out = 0;
    mem_if.mem_rvalid = 1'b0;
    #1;
    check("midreset_vga_data", 32'(vga_data), 0);
    check("midreset_mem_req", 32'(mem_if.mem_req), 0);
    check("midreset_mem_addr", 32'(mem_if.mem_addr), 0);
    check("midreset_fetch_busy", 32'(fetch_busy), 0);
    check("midreset_underrun", 32'(underrun), 0);
    cycles(3);
    reset_n = 1'b1;
    cycles(50);
    check("post_reset_idle_req", 32'(mem_if.mem_req), 0);
    check("post_reset_idle_busy", 32'(fetch_busy), 0);
    push_fetch(1);
    set_v(3);
    wait_fetch("row1_after_reset", 2000, used);
    check("post_reset_underrun", 32'(underrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
